// File: rtl/syn_accum.sv
`default_nettype none
// ============================================================================
// syn_accum : serial synaptic weight accumulator feeding a LIF neuron
// Revision  : 1.0
// ============================================================================
module syn_accum #(
  parameter  int W_WID   = 8,
  parameter  int W_NUM   = 4,
  localparam int AW      = $clog2(W_NUM),
  localparam int ACC_WID = W_WID + AW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_we,
  input  logic [AW-1:0]           w_addr,
  input  logic signed [W_WID-1:0] w_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W_NUM-1:0]        in_spikes,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              ir
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, OUT = 2'd2} state_t;

  localparam logic [AW-1:0] LAST  = AW'(W_NUM - 1);
  localparam logic [AW:0]   NUM_C = (AW + 1)'(W_NUM);

  state_t                    state, state_nxt;
  logic signed [W_WID-1:0]   weights [W_NUM];
  logic [W_NUM-1:0]          spikes;
  logic [AW-1:0]             idx;
  logic signed [ACC_WID-1:0] acc;
  logic signed [ACC_WID-1:0] addend;
  logic signed [ACC_WID-1:0] acc_sum;
  logic signed [31:0]        sum_wide;
  logic [7:0]                sat;
  logic                      write_ok;

  // Non-power-of-2 register files silently drop writes past the last synapse.
  assign write_ok = ({1'b0, w_addr} < NUM_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W_NUM; i++) weights[i] <= '0;
    end else if (w_we && write_ok) begin
      weights[w_addr] <= w_data;
    end
  end

  assign addend   = spikes[idx] ? {{(ACC_WID-W_WID){weights[idx][W_WID-1]}}, weights[idx]}
                                : '0;
  assign acc_sum  = acc + addend;
  assign sum_wide = {{(32-ACC_WID){acc_sum[ACC_WID-1]}}, acc_sum};

  always_comb begin
    if (sum_wide > 32'sd127)       sat = 8'h7f;
    else if (sum_wide < -32'sd128) sat = 8'h80;
    else                           sat = sum_wide[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (idx == LAST) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spikes <= '0;
      acc    <= '0;
      idx    <= '0;
      ir     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            spikes <= in_spikes;
            acc    <= '0;
            idx    <= '0;
          end
        end
        ACCUM: begin
          acc <= acc_sum;
          idx <= idx + 1'b1;
          if (idx == LAST) ir <= sat;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_syn_accum.sv
`default_nettype none
// Scoreboard bench for syn_accum: directed vectors, queued expectations, output monitor.
module tb_syn_accum;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              w_we;
  logic [1:0]        w_addr;
  logic [7:0]        w_data;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_spikes;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] ir;

  int checks = 0;
  int fails  = 0;
  int sb[$];

  syn_accum #(.W_WID(8), .W_NUM(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_spikes (in_spikes),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ir        (ir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Transfers happen at the next rising edge; inputs are stable by the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: got ir=%0d, expected no transfer", ir);
        end else begin
          chk("ir_out", int'(ir), sb.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int addr, input int val);
    w_we   = 1'b1;
    w_addr = 2'(addr);
    w_data = 8'(val);
    step();
    w_we   = 1'b0;
  endtask

  task automatic load4(input int a, input int b, input int c, input int d);
    write_w(0, a);
    write_w(1, b);
    write_w(2, c);
    write_w(3, d);
  endtask

  // Present a vector and wait for the handshake; returns just after the accept edge.
  task automatic accept(input logic [3:0] sp);
    int n;
    in_spikes = sp;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("accept_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  // Full transaction with latency and busy checks; returns in the OUT cycle.
  task automatic run_vec(input logic [3:0] sp, input int exp_ir);
    int n;
    sb.push_back(exp_ir);
    accept(sp);
    n = 0;
    while (!out_valid && n < 20) begin
      if (in_ready) begin
        checks++;
        fails++;
        $display("FAIL busy_in_ready: got 1, expected 0 at %0t", $time);
      end
      step();
      n++;
    end
    chk("latency_cycles", n + 1, 5);
  endtask

  initial begin
    rst_n     = 1'b0;
    w_we      = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    in_valid  = 1'b0;
    in_spikes = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ir", int'(ir), 0);
    rst_n = 1'b1;
    step();

    // 1: basic sum 10 - 3 + 50
    load4(10, -3, 100, 50);
    run_vec(4'b1011, 57);
    step();
    chk("t1_idle_ready", int'(in_ready), 1);
    chk("t1_idle_valid", int'(out_valid), 0);

    // 2: positive then negative saturation
    run_vec(4'b1101, 127);
    step();
    load4(-100, -100, -100, -100);
    run_vec(4'b1111, -128);
    step();

    // 3: empty vector; in_valid during OUT must be ignored
    out_ready = 1'b0;
    run_vec(4'b0000, 0);
    in_valid  = 1'b1;
    in_spikes = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      chk("t3_ready_in_out", int'(in_ready), 0);
      chk("t3_valid_in_out", int'(out_valid), 1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t3_back_idle", int'(in_ready), 1);

    // 4: backpressure hold for 6 cycles
    out_ready = 1'b0;
    run_vec(4'b0001, -100);
    for (int i = 0; i < 6; i++) begin
      chk("t4_hold_valid", int'(out_valid), 1);
      chk("t4_hold_ir", int'(ir), -100);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("t4_release_valid", int'(out_valid), 0);
    chk("t4_release_ready", int'(in_ready), 1);

    // 5: weight writes while accumulating: w0 already summed, w3 not yet
    load4(10, -3, 100, 50);
    sb.push_back(107);
    accept(4'b1111);
    step();
    w_we = 1'b1; w_addr = 2'd0; w_data = 8'd127;
    step();
    w_addr = 2'd3; w_data = 8'd0;
    step();
    w_we = 1'b0;
    step();
    chk("t5_out_valid", int'(out_valid), 1);
    step();
    run_vec(4'b0001, 127);
    step();

    // 6: async reset in the 2nd accumulate cycle clears everything
    accept(4'b1111);
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_ir", int'(ir), 0);
    chk("t6_rst_ready", int'(in_ready), 1);
    step();
    step();
    rst_n = 1'b1;
    step();
    run_vec(4'b1111, 0);
    step();
    step();

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish, expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/syn_accum.md
Name: syn_accum

Overview:
- Synaptic input stage that sits directly upstream of the LIF neuron.
- Accepts one vector of W_NUM input spikes per time step over a valid/ready handshake.
- Serially sums the signed weights of the active synapses, one synapse per cycle, from an internal weight register file.
- Saturates the sum to signed 8 bits and presents it as the neuron input current `ir` over a valid/ready handshake.

Parameters:
- W_WID, 8, signed weight width in bits (2..16).
- W_NUM, 4, number of synapses (≥2); also the width of the spike vector.
- AW, $clog2(W_NUM), derived localparam: weight address width.
- ACC_WID, W_WID+AW+1, derived localparam: accumulator width; sized so the sum cannot overflow.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_we  in  1  weight write enable.
- w_addr  in  AW  weight write address.
- w_data  in  W_WID  signed weight write data.
- in_valid  in  1  spike vector valid.
- in_ready  out  1  block can accept a spike vector.
- in_spikes  in  W_NUM  spike vector; bit k selects weight k.
- out_valid  out  1  `ir` valid.
- out_ready  in  1  downstream accepts `ir`.
- ir  out  8  signed saturated synaptic current.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, all weights=0, acc=0, idx=0, spike latch=0.
  - ir=0, out_valid=0, in_ready=1 (in_ready is combinational, =1 iff state==IDLE).
- States: IDLE, ACCUM, OUT.
- IDLE:
  - On in_valid&&in_ready (cycle T): latch in_spikes, clear acc, idx=0, go to ACCUM.
  - in_valid without the handshake is ignored and has no effect.
- ACCUM (cycles T+1..T+W_NUM):
  - Each cycle: if spike[idx] then acc += sign-extended weight[idx]; idx++.
  - When idx==W_NUM-1, do that final add, then go to OUT.
  - idx wrap is not used; it returns to 0 on entering the next transaction.
- OUT:
  - Entered at cycle T+W_NUM+1 with ir registered and out_valid=1.
  - Total latency is W_NUM+1 cycles from accept to out_valid.
  - ir = acc clamped to [-128,127].
  - ir and out_valid are held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid←0, go to IDLE; in_ready rises next cycle. No overlap, so throughput is one vector per W_NUM+2 cycles minimum.
- Empty spike vector (all zero): still runs the full ACCUM sequence; ir=0.
- Weight port:
  - Write is registered and independent of state; the new value is visible from the next cycle.
  - During ACCUM, a same-cycle read of the written address returns the old value.
  - A write to an already-summed index does not affect the current result.
- Out-of-range w_addr (≥W_NUM, when W_NUM is not a power of 2): the write is ignored.
- Width rules:
  - Weights are two's complement, sign-extended to ACC_WID.
  - Saturation: acc>127 → 127; acc<-128 → -128; otherwise acc[7:0].
- Reset mid-operation: any state returns to IDLE immediately.
  - Weights clear to 0, so software must reload them.
  - Pending out_valid drops to 0 asynchronously.

Test Plan:
1. Load weights {w0..w3}={10,-3,100,50}; send in_spikes=4'b1011 with out_ready=1 → out_valid rises exactly 5 cycles after accept, ir=57, in_ready low for that interval.
2. Same weights, in_spikes=4'b1101 → sum 160, ir=127 (positive saturation). Then all weights=-100, in_spikes=4'b1111 → sum -400, ir=-128.
3. in_spikes=4'b0000 → ir=0 after 5 cycles; also, in_valid asserted while in OUT is ignored (in_ready=0) until the output handshake completes.
4. Backpressure: hold out_ready=0 for 6 cycles in OUT → ir and out_valid stable; release → one transfer, IDLE next cycle, in_ready=1.
5. Weights {10,-3,100,50}, in_spikes=4'b1111; during the 2nd ACCUM cycle write w0=127 and w3=0 → ir=107 (w3 change seen, w0 change not); next vector 4'b0001 → ir=127.
6. Assert rst_n=0 during the 2nd ACCUM cycle → out_valid=0, ir=0, in_ready=1 immediately; after release, in_spikes=4'b1111 → ir=0 (weights cleared).
